// File: rtl/banco_reg_param_pkg.sv
// banco_reg_param_pkg: shared defaults and packed-port slicing for the register file
package banco_reg_param_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int REG_ZERO = 0;
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/banco_reg_scoreboard.sv
// banco_reg_scoreboard: per-register pending bits, reserve/clear and busy lookups
module banco_reg_scoreboard
  import banco_reg_param_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic              res_valid,
  input  logic [AW-1:0]     res_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              busy_any
);
  logic [NREG-1:0] pend_q, pend_d;
  logic clr_en, set_en;
  assign clr_en = we && wr_addr != AW'(REG_ZERO);
  assign set_en = res_valid && res_addr != AW'(REG_ZERO);
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[wr_addr] = 1'b0;
    // reserve last: a newly issued producer supersedes the one retiring now
    if (set_en) pend_d[res_addr] = 1'b1;
  end
  always_ff @(posedge clk) pend_q <= rst ? '0 : pend_d;
  assign busy_any = |pend_q;
  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [AW-1:0] a;
    logic hit;
    assign a = rd_addr[port_lsb(k, AW) +: AW];
    assign hit = BYPASS != 0 && clr_en && wr_addr == a && !(set_en && res_addr == a);
    assign rd_busy[k] = pend_q[a] && !hit;
  end
endmodule

// File: rtl/banco_reg_param.sv
// banco_reg_param: parametrised register file with hardwired x0, write-through bypass and scoreboard
module banco_reg_param
  import banco_reg_param_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = NRD_DEF,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                res_valid,
  input  logic [AW-1:0]       res_addr,
  output logic                busy_any
);
  logic [XLEN-1:0] regs_q [NREG];
  logic wr_en;
  assign wr_en = we && wr_addr != AW'(REG_ZERO);
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    else if (wr_en) regs_q[wr_addr] <= wr_data;
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[port_lsb(k, AW) +: AW];
    assign rd_data[port_lsb(k, XLEN) +: XLEN] = a == AW'(REG_ZERO) ? '0 :
      (BYPASS != 0 && wr_en && wr_addr == a) ? wr_data : regs_q[a];
  end
  banco_reg_scoreboard #(.NREG(NREG), .NRD(NRD), .BYPASS(BYPASS)) u_sb (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wr_addr(wr_addr),
    .res_valid(res_valid),
    .res_addr(res_addr),
    .rd_addr(rd_addr),
    .rd_busy(rd_busy),
    .busy_any(busy_any)
  );
endmodule

// File: tb/tb_banco_reg_param.sv
// tb_banco_reg_param: directed and randomized checks of bypass, no-bypass and wide instances
module tb_banco_reg_param;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] rd_addr;
  logic we, res_valid;
  logic [4:0] wr_addr, res_addr;
  logic [31:0] wr_data;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0] rd_busy_a, rd_busy_b;
  logic busy_any_a, busy_any_b;
  logic [11:0] rd_addr_c;
  logic we_c, res_valid_c;
  logic [3:0] wr_addr_c, res_addr_c;
  logic [63:0] wr_data_c;
  logic [191:0] rd_data_c;
  logic [2:0] rd_busy_c;
  logic busy_any_c;
  logic [31:0] m [32];
  logic [31:0] pm;
  logic [63:0] mc [16];
  logic [15:0] pmc;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  banco_reg_param #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .res_valid(res_valid), .res_addr(res_addr),
    .busy_any(busy_any_a)
  );
  banco_reg_param #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .res_valid(res_valid), .res_addr(res_addr),
    .busy_any(busy_any_b)
  );
  banco_reg_param #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .we(we_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c), .res_valid(res_valid_c),
    .res_addr(res_addr_c), .busy_any(busy_any_c)
  );

  // reference model: the architectural effect of one clock edge
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      for (int i = 0; i < 16; i++) mc[i] = '0;
      pm = '0;
      pmc = '0;
    end else begin
      if (we && wr_addr != 0) begin m[wr_addr] = wr_data; pm[wr_addr] = 1'b0; end
      if (res_valid && res_addr != 0) pm[res_addr] = 1'b1;
      if (we_c && wr_addr_c != 0) begin mc[wr_addr_c] = wr_data_c; pmc[wr_addr_c] = 1'b0; end
      if (res_valid_c && res_addr_c != 0) pmc[res_addr_c] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; res_valid = 0; we_c = 0; res_valid_c = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && we && wr_addr == a) return wr_data;
    return m[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && we && wr_addr == a && !(res_valid && res_addr == a)) return 1'b0;
    return pm[a];
  endfunction

  function automatic logic [63:0] exp_rd_c(input logic [3:0] a);
    if (a == 0) return '0;
    if (we_c && wr_addr_c == a) return wr_data_c;
    return mc[a];
  endfunction

  function automatic logic exp_bz_c(input logic [3:0] a);
    if (a == 0) return 1'b0;
    if (we_c && wr_addr_c == a && !(res_valid_c && res_addr_c == a)) return 1'b0;
    return pmc[a];
  endfunction

  task automatic test_reset();
    idle();
    rst = 1; we = 1; wr_addr = 5'd4; wr_data = 32'hFFFF_FFFF; res_valid = 1; res_addr = 5'd4;
    tick();
    idle();
    rd_addr = {5'd1, 5'd0};
    rd_addr_c = {4'd2, 4'd1, 4'd0};
    #1;
    n_chk++; if (rd_data_a !== 64'h0) begin n_fail++; $display("FAIL reset_data_a: got %h want 0", rd_data_a); end
    n_chk++; if (rd_data_b !== 64'h0) begin n_fail++; $display("FAIL reset_data_b: got %h want 0", rd_data_b); end
    n_chk++; if (rd_busy_a !== 2'b00 || busy_any_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b/%b want 00/0", rd_busy_a, busy_any_a); end
    n_chk++; if (rd_data_c !== 192'h0 || busy_any_c !== 1'b0) begin n_fail++; $display("FAIL reset_c: got %h/%b want 0/0", rd_data_c, busy_any_c); end
  endtask

  task automatic test_x0();
    we = 1; wr_addr = 5'd0; wr_data = 32'h1234_5678; rd_addr = {5'd0, 5'd0};
    we_c = 1; wr_addr_c = 4'd0; wr_data_c = 64'h0123_4567_89AB_CDEF; rd_addr_c = '0;
    #1;
    n_chk++; if (rd_data_a !== 64'h0) begin n_fail++; $display("FAIL x0_bypass: got %h want 0", rd_data_a); end
    n_chk++; if (rd_data_c !== 192'h0) begin n_fail++; $display("FAIL x0_bypass_c: got %h want 0", rd_data_c); end
    tick();
    idle();
    #1;
    n_chk++; if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin n_fail++; $display("FAIL x0_after: got %h/%h want 0", rd_data_a, rd_data_b); end
    n_chk++; if (rd_data_c !== 192'h0) begin n_fail++; $display("FAIL x0_after_c: got %h want 0", rd_data_c); end
  endtask

  task automatic test_readback();
    we = 1; wr_addr = 5'd1; wr_data = 32'hDEAD_BEEF;
    we_c = 1; wr_addr_c = 4'd1; wr_data_c = 64'hDEAD_BEEF_0BAD_F00D;
    tick();
    wr_addr = 5'd2; wr_data = 32'hCAFE_BABE;
    wr_addr_c = 4'd2; wr_data_c = 64'hCAFE_BABE_1234_5678;
    tick();
    we = 0;
    wr_addr_c = 4'd15; wr_data_c = 64'hA5A5_5A5A_F0F0_0F0F;
    tick();
    idle();
    rd_addr = {5'd2, 5'd1};
    rd_addr_c = {4'd15, 4'd2, 4'd1};
    #1;
    n_chk++; if (rd_data_a !== {32'hCAFE_BABE, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL readback_a: got %h want CAFEBABEDEADBEEF", rd_data_a); end
    n_chk++; if (rd_data_b !== {32'hCAFE_BABE, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL readback_b: got %h want CAFEBABEDEADBEEF", rd_data_b); end
    n_chk++; if (rd_data_c !== {64'hA5A5_5A5A_F0F0_0F0F, 64'hCAFE_BABE_1234_5678, 64'hDEAD_BEEF_0BAD_F00D}) begin n_fail++; $display("FAIL readback_c: got %h", rd_data_c); end
    rd_addr = {5'd1, 5'd2};
    rd_addr_c = {4'd1, 4'd15, 4'd2};
    #1;
    n_chk++; if (rd_data_a !== {32'hDEAD_BEEF, 32'hCAFE_BABE}) begin n_fail++; $display("FAIL swap_a: got %h want DEADBEEFCAFEBABE", rd_data_a); end
    n_chk++; if (rd_data_c !== {64'hDEAD_BEEF_0BAD_F00D, 64'hA5A5_5A5A_F0F0_0F0F, 64'hCAFE_BABE_1234_5678}) begin n_fail++; $display("FAIL swap_c: got %h", rd_data_c); end
    rd_addr_c = {4'd2, 4'd2, 4'd2};
    #1;
    n_chk++; if (rd_data_c !== {3{64'hCAFE_BABE_1234_5678}}) begin n_fail++; $display("FAIL same_addr_c: got %h", rd_data_c); end
  endtask

  task automatic test_bypass();
    rd_addr = {5'd0, 5'd3}; we = 1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5;
    #1;
    n_chk++; if (rd_data_a[31:0] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_on: got %h want a5a5a5a5", rd_data_a[31:0]); end
    n_chk++; if (rd_data_b[31:0] !== 32'h0) begin n_fail++; $display("FAIL bypass_off_pre: got %h want 0", rd_data_b[31:0]); end
    tick();
    idle();
    #1;
    n_chk++; if (rd_data_b[31:0] !== 32'hA5A5_A5A5 || rd_data_a[31:0] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_post: got %h/%h want a5a5a5a5", rd_data_a[31:0], rd_data_b[31:0]); end
  endtask

  task automatic test_scoreboard();
    rd_addr = {5'd0, 5'd5}; res_valid = 1; res_addr = 5'd5;
    #1;
    n_chk++; if (rd_busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL reserve_same_cycle: got %b want 0", rd_busy_a[0]); end
    tick();
    idle();
    #1;
    n_chk++; if (rd_busy_a !== 2'b01 || busy_any_a !== 1'b1 || rd_busy_b[0] !== 1'b1) begin n_fail++; $display("FAIL reserve_busy: got %b/%b/%b want 01/1/1", rd_busy_a, busy_any_a, rd_busy_b[0]); end
    we = 1; wr_addr = 5'd5; wr_data = 32'h55;
    #1;
    n_chk++; if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b1 || busy_any_a !== 1'b1) begin n_fail++; $display("FAIL write_clear_bypass: got %b/%b/%b want 0/1/1", rd_busy_a[0], rd_busy_b[0], busy_any_a); end
    tick();
    idle();
    #1;
    n_chk++; if (rd_busy_a[0] !== 1'b0 || busy_any_a !== 1'b0 || busy_any_b !== 1'b0 || rd_data_a[31:0] !== 32'h55) begin n_fail++; $display("FAIL write_clear: got %b/%b/%b/%h want 0/0/0/55", rd_busy_a[0], busy_any_a, busy_any_b, rd_data_a[31:0]); end
    rd_addr = {5'd0, 5'd6}; we = 1; wr_addr = 5'd6; wr_data = 32'h66; res_valid = 1; res_addr = 5'd6;
    tick();
    idle();
    #1;
    n_chk++; if (rd_data_a[31:0] !== 32'h66 || rd_busy_a[0] !== 1'b1 || busy_any_a !== 1'b1) begin n_fail++; $display("FAIL reserve_wins: got %h/%b/%b want 66/1/1", rd_data_a[31:0], rd_busy_a[0], busy_any_a); end
    we = 1; wr_addr = 5'd6; wr_data = 32'h67; res_valid = 1; res_addr = 5'd6;
    #1;
    n_chk++; if (rd_busy_a[0] !== 1'b1) begin n_fail++; $display("FAIL reissue_busy: got %b want 1", rd_busy_a[0]); end
    idle();
    we = 1; wr_addr = 5'd6; wr_data = 32'h68; res_valid = 1; res_addr = 5'd9;
    tick();
    idle();
    rd_addr = {5'd9, 5'd6};
    #1;
    n_chk++; if (rd_busy_a !== 2'b10 || rd_data_a[31:0] !== 32'h68) begin n_fail++; $display("FAIL diff_addr: got %b/%h want 10/68", rd_busy_a, rd_data_a[31:0]); end
  endtask

  task automatic test_mid_reset();
    res_valid = 1; res_addr = 5'd7;
    tick();
    idle();
    we = 1; wr_addr = 5'd8; wr_data = 32'h88;
    tick();
    idle();
    rst = 1; we = 1; wr_addr = 5'd9; wr_data = 32'h99; res_valid = 1; res_addr = 5'd10;
    tick();
    idle();
    rd_addr = {5'd8, 5'd7};
    #1;
    n_chk++; if (rd_busy_a !== 2'b00 || busy_any_a !== 1'b0 || rd_data_a !== 64'h0) begin n_fail++; $display("FAIL mid_reset_a: got %b/%b/%h want 0", rd_busy_a, busy_any_a, rd_data_a); end
    rd_addr = {5'd10, 5'd9};
    #1;
    n_chk++; if (rd_data_a !== 64'h0 || rd_busy_b !== 2'b00) begin n_fail++; $display("FAIL mid_reset_r9: got %h/%b want 0/00", rd_data_a, rd_busy_b); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      we = $urandom_range(0, 1); wr_addr = 5'($urandom_range(0, 7)); wr_data = $urandom;
      res_valid = ($urandom_range(0, 3) == 0); res_addr = 5'($urandom_range(0, 7));
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      we_c = $urandom_range(0, 1); wr_addr_c = 4'($urandom_range(0, 5)); wr_data_c = {$urandom, $urandom};
      res_valid_c = ($urandom_range(0, 3) == 0); res_addr_c = 4'($urandom_range(0, 5));
      rd_addr_c = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      #1;
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (rd_data_a[k*32 +: 32] !== exp_rd(rd_addr[k*5 +: 5], 1'b1) || rd_busy_a[k] !== exp_bz(rd_addr[k*5 +: 5], 1'b1)) begin
          n_fail++; $display("FAIL rand_a[%0d] n=%0d: got %h/%b want %h/%b", k, n, rd_data_a[k*32 +: 32], rd_busy_a[k], exp_rd(rd_addr[k*5 +: 5], 1'b1), exp_bz(rd_addr[k*5 +: 5], 1'b1));
        end
        n_chk++;
        if (rd_data_b[k*32 +: 32] !== exp_rd(rd_addr[k*5 +: 5], 1'b0) || rd_busy_b[k] !== exp_bz(rd_addr[k*5 +: 5], 1'b0)) begin
          n_fail++; $display("FAIL rand_b[%0d] n=%0d: got %h/%b want %h/%b", k, n, rd_data_b[k*32 +: 32], rd_busy_b[k], exp_rd(rd_addr[k*5 +: 5], 1'b0), exp_bz(rd_addr[k*5 +: 5], 1'b0));
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rd_data_c[k*64 +: 64] !== exp_rd_c(rd_addr_c[k*4 +: 4]) || rd_busy_c[k] !== exp_bz_c(rd_addr_c[k*4 +: 4])) begin
          n_fail++; $display("FAIL rand_c[%0d] n=%0d: got %h/%b want %h/%b", k, n, rd_data_c[k*64 +: 64], rd_busy_c[k], exp_rd_c(rd_addr_c[k*4 +: 4]), exp_bz_c(rd_addr_c[k*4 +: 4]));
        end
      end
      n_chk++;
      if (busy_any_a !== (|pm) || busy_any_b !== (|pm) || busy_any_c !== (|pmc)) begin
        n_fail++; $display("FAIL rand_busy_any n=%0d: got %b/%b/%b want %b/%b", n, busy_any_a, busy_any_b, busy_any_c, |pm, |pmc);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; res_addr = '0;
    rd_addr_c = '0; wr_addr_c = '0; wr_data_c = '0; res_addr_c = '0;
    test_reset();
    test_x0();
    test_readback();
    test_bypass();
    test_scoreboard();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
